// File: rtl/btn_pkg.sv
// Shared types and helpers for the button/switch input conditioner.
package btn_pkg;

  localparam int unsigned SW_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    HELD,
    REPEAT,
    DB_RELEASE
  } btn_state_e;

  // Millisecond interval to clock cycles, never less than one cycle.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    int unsigned cyc;
    cyc = (clk_hz / 32'd1000) * ms;
    return (cyc == 32'd0) ? 32'd1 : cyc;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser with an optional stable-time debouncer.
// DB_CYC = 0 builds the synchroniser alone; level is then the synchronised input.
module sync_debounce #(
  parameter int unsigned DB_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], raw};
  end

  generate
    if (DB_CYC == 0) begin : g_sync_only
      assign level = sync_q[1];
    end else begin : g_debounce
      localparam int unsigned CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
      logic [CNT_W-1:0] cnt;

      // Accept a new level only after DB_CYC consecutive disagreeing samples.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt   <= '0;
          level <= 1'b0;
        end else if (sync_q[1] != level) begin
          if (cnt == CNT_W'(DB_CYC - 1)) begin
            level <= sync_q[1];
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/btn_conditioner.sv
// Button and mode-switch front end: debounce, press pulse, optional hold-to-repeat.
// Define AUTOREPEAT_EN to build the REPEAT state and repeat timing.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            BTNL,
  input  logic [SW_W-1:0] sw,
  output logic            btn_level,
  output logic            btn_pulse,
  output logic            btn_hold,
  output logic [SW_W-1:0] sw_out,
  output logic            sw_changed
);

  localparam int unsigned DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned DLY_CYC  = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int unsigned RATE_CYC = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
  localparam int unsigned MAX_A    = (DB_CYC > DLY_CYC) ? DB_CYC : DLY_CYC;
  localparam int unsigned MAX_CYC  = (MAX_A > RATE_CYC) ? MAX_A : RATE_CYC;
  localparam int unsigned CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic             sync_in;
  logic [SW_W-1:0]  sw_db;
  logic [SW_W-1:0]  sw_q;
  btn_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, pulse_n;

  // Button path: synchroniser only, the FSM below owns the timing.
  sync_debounce #(.DB_CYC(0)) u_btn_sync (
    .clk   (clk),
    .rst   (rst),
    .raw   (BTNL),
    .level (sync_in)
  );

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    sync_debounce #(.DB_CYC(DB_CYC)) u_sw_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw[i]),
      .level (sw_db[i])
    );
  end

  assign sw_out = sw_db;

  // sw_q lags sw_out by one cycle, so the strobe lands the cycle after an update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_q       <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_q       <= sw_db;
      sw_changed <= |(sw_db ^ sw_q);
    end
  end

`ifdef AUTOREPEAT_EN
  logic hold_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_hold <= 1'b0;
    else      btn_hold <= hold_n;
  end
`else
  assign btn_hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      btn_level <= level_n;
      btn_pulse <= pulse_n;
    end
  end

  // Release is tested first in every held state, so it beats a coincident expiry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    level_n = btn_level;
    pulse_n = 1'b0;
`ifdef AUTOREPEAT_EN
    hold_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        level_n = 1'b0;
        cnt_n   = '0;
        if (sync_in) state_n = DB_PRESS;
      end
      DB_PRESS: begin
        if (!sync_in) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(DB_CYC - 1)) begin
          state_n = HELD;
          cnt_n   = '0;
          level_n = 1'b1;
          pulse_n = 1'b1;
        end
      end
      HELD: begin
        level_n = 1'b1;
        if (!sync_in) begin
          state_n = DB_RELEASE;
          cnt_n   = '0;
        end
`ifdef AUTOREPEAT_EN
        else if (cnt == CNT_W'(DLY_CYC - 1)) begin
          state_n = REPEAT;
          cnt_n   = '0;
          pulse_n = 1'b1;
          hold_n  = 1'b1;
        end
`else
        else cnt_n = '0;
`endif
      end
`ifdef AUTOREPEAT_EN
      REPEAT: begin
        level_n = 1'b1;
        if (!sync_in) begin
          state_n = DB_RELEASE;
          cnt_n   = '0;
        end else begin
          hold_n = 1'b1;
          if (cnt == CNT_W'(RATE_CYC - 1)) begin
            cnt_n   = '0;
            pulse_n = 1'b1;
          end
        end
      end
`endif
      DB_RELEASE: begin
        level_n = 1'b1;
        if (sync_in) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(DB_CYC - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          level_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed timeline checks plus random
// stimulus against a run-length reference model. Honours AUTOREPEAT_EN.
module tb_btn_conditioner;

  localparam int DB   = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam logic [63:0] EXP_CLEAN_AR = (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) |
                                         (64'd1 << 22) | (64'd1 << 25) | (64'd1 << 28);
  localparam logic [63:0] EXP_BOUNCE_AR = (64'd1 << 6) | (64'd1 << 27) | (64'd1 << 30) |
                                          (64'd1 << 33);
  localparam logic [63:0] ONLY_6 = 64'd1 << 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       BTNL = 1'b0;
  logic [2:0] sw = 3'b000;
  logic       btn_level, btn_pulse, btn_hold, sw_changed;
  logic [2:0] sw_out;

  always #5 clk = ~clk;

  btn_conditioner #(
    .CLK_HZ          (1000),
    .DEBOUNCE_MS     (4),
    .REPEAT_DELAY_MS (10),
    .REPEAT_RATE_MS  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .BTNL       (BTNL),
    .sw         (sw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_hold   (btn_hold),
    .sw_out     (sw_out),
    .sw_changed (sw_changed)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs seen two edges late, then judged by run lengths.
  bit       bd1, bd2, m_lvl, m_pulse, m_hold, m_chg, m_flip;
  bit [2:0] sd1, sd2, m_sw;
  int       hi, lo, since;
  int       swc [3];

  task automatic model_reset();
    bd1 = 0; bd2 = 0; sd1 = '0; sd2 = '0;
    m_lvl = 0; m_pulse = 0; m_hold = 0; m_chg = 0; m_flip = 0; m_sw = '0;
    hi = 0; lo = 0; since = 0;
    for (int i = 0; i < 3; i++) swc[i] = 0;
  endtask

  task automatic model_step(input bit b, input bit [2:0] s);
    bit       seen, flip;
    bit [2:0] sseen;
    seen = bd2; bd2 = bd1; bd1 = b;
    sseen = sd2; sd2 = sd1; sd1 = s;
    m_pulse = 0;
    m_hold  = 0;
    if (!m_lvl) begin
      if (seen) begin
        hi++;
        if (hi == DB + 1) begin
          m_lvl = 1; m_pulse = 1; hi = 0; lo = 0; since = 0;
        end
      end else hi = 0;
    end else if (seen) begin
      if (lo > 0) begin
        lo = 0; since = 0;
      end else begin
        since++;
        if (AR && since >= DLY && (since - DLY) % RATE == 0) m_pulse = 1;
      end
      m_hold = AR && since >= DLY;
    end else begin
      lo++;
      if (lo == DB + 1) begin
        m_lvl = 0; lo = 0; hi = 0;
      end
    end
    m_chg = m_flip;
    flip  = 0;
    for (int i = 0; i < 3; i++) begin
      if (sseen[i] != m_sw[i]) begin
        swc[i]++;
        if (swc[i] == DB) begin
          m_sw[i] = sseen[i]; swc[i] = 0; flip = 1;
        end
      end else swc[i] = 0;
    end
    m_flip = flip;
  endtask

  // One clock: apply inputs, let the edge sample them, then compare with the model.
  task automatic step(input bit b, input bit [2:0] s);
    BTNL = b;
    sw   = s;
    @(posedge clk);
    #1;
    model_step(b, s);
    check("btn_level", btn_level, m_lvl);
    check("btn_pulse", btn_pulse, m_pulse);
    check("btn_hold", btn_hold, m_hold);
    check("sw_out", sw_out, m_sw);
    check("sw_changed", sw_changed, m_chg);
  endtask

  task automatic idle(input int n, input bit [2:0] s);
    for (int i = 0; i < n; i++) step(1'b0, s);
  endtask

  logic [63:0] hist;
  int          first_hold, fall, cnt_a, cnt_b;
  bit [2:0]    cur_sw;

  initial begin
    model_reset();
    #12;
    check("rst_level", btn_level, 1'b0);
    check("rst_pulse", btn_pulse, 1'b0);
    check("rst_hold", btn_hold, 1'b0);
    check("rst_sw_out", sw_out, 3'b000);
    check("rst_sw_changed", sw_changed, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(10, 3'b000);

    // Clean hold: high for cycles 0..28.
    hist = '0; first_hold = -1; fall = -1;
    for (int i = 0; i <= 40; i++) begin
      step(i <= 28, 3'b000);
      hist[i] = btn_pulse;
      if (btn_hold && first_hold < 0) first_hold = i;
      if (i > 28 && !btn_level && fall < 0) fall = i;
    end
    check("clean_pulses", hist, AR ? EXP_CLEAN_AR : ONLY_6);
    check("clean_hold_start", first_hold, AR ? 16 : -1);
    check("clean_level_fall", fall, 35);
    idle(10, 3'b000);

    // Long 40-cycle hold.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i <= 50; i++) begin
      step(i < 40, 3'b000);
      if (btn_pulse) cnt_a++;
      if (btn_hold) cnt_b++;
    end
    check("long_pulse_count", cnt_a, AR ? 10 : 1);
    check("long_hold_seen", cnt_b > 0, AR);
    idle(10, 3'b000);

    // Three-cycle glitch.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      step(i < 3, 3'b000);
      if (btn_pulse) cnt_a++;
      if (btn_level) cnt_b++;
    end
    check("glitch_pulses", cnt_a, 0);
    check("glitch_level", cnt_b, 0);
    idle(5, 3'b000);

    // Release bounce: low for cycles 13..14, released for good at 34.
    hist = '0; cnt_a = 0; fall = -1;
    for (int i = 0; i <= 50; i++) begin
      step((i <= 12) || (i >= 15 && i <= 33), 3'b000);
      hist[i] = btn_pulse;
      if (i >= 6 && i < 40 && !btn_level) cnt_a++;
      if (i >= 34 && !btn_level && fall < 0) fall = i;
    end
    check("bounce_pulses", hist, AR ? EXP_BOUNCE_AR : ONLY_6);
    check("bounce_level_kept", cnt_a, 0);
    check("bounce_level_fall", fall, 40);
    idle(10, 3'b000);

    // Reset in the middle of auto-repeat, button still held afterwards.
    for (int i = 0; i < 20; i++) step(1'b1, 3'b000);
    #2 rst = 1'b0;
    #1;
    check("midrst_level", btn_level, 1'b0);
    check("midrst_pulse", btn_pulse, 1'b0);
    check("midrst_hold", btn_hold, 1'b0);
    check("midrst_sw_changed", sw_changed, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    hist = '0;
    for (int i = 0; i <= 10; i++) begin
      step(1'b1, 3'b000);
      hist[i] = btn_pulse;
    end
    check("midrst_repress", hist, ONLY_6);
    idle(15, 3'b000);

    // Switch change 000 -> 010, then a 2-cycle glitch on bit 0.
    hist = '0; fall = -1;
    for (int i = 0; i <= 12; i++) begin
      step(1'b0, 3'b010);
      hist[i] = sw_changed;
      if (sw_out == 3'b010 && fall < 0) fall = i;
    end
    check("sw_change_strobe", hist, ONLY_6);
    check("sw_update_cycle", fall, 5);
    check("sw_settled", sw_out, 3'b010);
    cnt_a = 0;
    for (int i = 0; i <= 12; i++) begin
      step(1'b0, (i < 2) ? 3'b011 : 3'b010);
      if (sw_changed) cnt_a++;
    end
    check("sw_glitch_strobe", cnt_a, 0);
    check("sw_glitch_level", sw_out, 3'b010);

    // Random bouncing button and switches against the model.
    cur_sw = 3'b010;
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      bit b;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 6));
      b   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) cur_sw = 3'($urandom);
      for (int k = 0; k < len; k++) step(b, cur_sw);
    end
    idle(12, cur_sw);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
